// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the transmitter state encoding.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is dropped
// and reported, even if a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == CNT_MAX);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_dout   = r_mem[r_rdPtr];
   assign o_drop   = i_push && o_full;
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register decode, baud divisor, transmit
// FIFO and the serializer FSM that drains it.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [3:0]  wen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int CW = $clog2(DEPTH) + 1;

   tx_state_t     r_state;
   logic [15:0]   r_div;
   logic [15:0]   r_timer;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitIdx;
   logic          r_tx;
   logic          r_ovf;
   logic [31:0]   r_rdata;

   logic          w_push;
   logic          w_pop;
   logic          w_ovfClr;
   logic [7:0]    w_fifoDout;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_drop;
   logic          w_timerDone;
   logic [15:0]   w_reload;
   logic [3:0]    w_cntSat;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_unused    = &{1'b0, wdata[31:16]};
   assign w_push      = sel && (addr == REG_DATA) && wen[0];
   assign w_ovfClr    = sel && (addr == REG_STATUS) && wen[0] && wdata[ST_OVF];
   assign w_timerDone = (r_timer == 16'd0);
   assign w_reload    = (r_div == 16'd0) ? 16'd0 : (r_div - 16'd1);
   assign w_pop       = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_timerDone));
   assign tx          = r_tx;
   assign rdata       = r_rdata;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_din   (wdata[7:0]),
      .i_pop   (w_pop),
      .o_dout  (w_fifoDout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_drop  (w_drop)
   );

   always_comb begin
      w_cntSat = 4'hF;
      if (32'(w_count) < 32'd15) begin
         w_cntSat = 4'(w_count);
      end
      w_status = '0;
      w_status[ST_BUSY]  = (r_state != IDLE);
      w_status[ST_FULL]  = w_full;
      w_status[ST_EMPTY] = w_empty;
      w_status[ST_OVF]   = r_ovf;
      w_status[ST_CNT_LSB +: 4] = w_cntSat;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div   <= DEFAULT_DIV;
         r_ovf   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (sel && (addr == REG_DIV)) begin
            if (wen[0]) r_div[7:0]  <= wdata[7:0];
            if (wen[1]) r_div[15:8] <= wdata[15:8];
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_ovfClr) begin
            r_ovf <= 1'b0;
         end
         if (!sel) begin
            r_rdata <= '0;
         end else begin
            case (addr)
               REG_STATUS: r_rdata <= w_status;
               REG_DIV:    r_rdata <= {16'b0, r_div};
               default:    r_rdata <= '0;
            endcase
         end
      end
   end

   // Divisor is sampled only on timer reload, so a bit in flight keeps its length.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_shift  <= '0;
         r_bitIdx <= '0;
         r_tx     <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_fifoDout;
                  r_timer <= w_reload;
                  r_tx    <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_timerDone) begin
                  r_timer  <= w_reload;
                  r_bitIdx <= 3'd0;
                  r_tx     <= r_shift[0];
                  r_state  <= DATA;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            DATA: begin
               if (w_timerDone) begin
                  r_timer <= w_reload;
                  if (r_bitIdx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_shift  <= r_shift >> 1;
                     r_bitIdx <= r_bitIdx + 3'd1;
                     r_tx     <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            STOP: begin
               if (w_timerDone) begin
                  if (w_pop) begin
                     r_shift <= w_fifoDout;
                     r_timer <= w_reload;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register access, frame waveforms
// against an ideal 8N1 line model, FIFO overflow and asynchronous reset.
module tb_mmio_uart_tx;

   localparam int DEPTH = 8;
   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_DIV    = 2'd2;
   localparam logic [1:0] A_RSVD   = 2'd3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        sel;
   logic [1:0]  addr;
   logic [3:0]  wen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;

   int errors = 0;
   int checks = 0;
   logic txLog[$];

   mmio_uart_tx #(
      .DEPTH       (DEPTH),
      .DEFAULT_DIV (16'd868)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .sel    (sel),
      .addr   (addr),
      .wen    (wen),
      .wdata  (wdata),
      .rdata  (rdata),
      .tx     (tx)
   );

   always #5 clk = ~clk;

   // One line sample per clock period, taken away from the active edge.
   always @(negedge clk) txLog.push_back(tx);

   task automatic busWrite(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; addr = a; wen = w; wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0; wen = 4'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; addr = a; wen = 4'b0;
      @(posedge clk);
      #1;
      d = rdata;
      sel = 1'b0;
   endtask

   // Ideal line: one idle-high sample, then per byte start(0), 8 data bits LSB
   // first, stop(1), each divEff samples long, then idle high to the log end.
   function automatic int frameMismatches(int startIdx, logic [7:0] bytes[$], int divEff);
      int bad;
      int endIdx;
      int bitPos;
      logic e;
      bad = 0;
      endIdx = startIdx + 1 + bytes.size() * 10 * divEff;
      if (txLog.size() <= endIdx) return 1 + endIdx - txLog.size();
      if (txLog[startIdx] !== 1'b1) bad++;
      for (int f = 0; f < bytes.size(); f++) begin
         for (int p = 0; p < 10 * divEff; p++) begin
            bitPos = p / divEff;
            if (bitPos == 0) e = 1'b0;
            else if (bitPos == 9) e = 1'b1;
            else e = bytes[f][bitPos-1];
            if (txLog[startIdx + 1 + f * 10 * divEff + p] !== e) bad++;
         end
      end
      for (int i = endIdx; i < txLog.size(); i++) begin
         if (txLog[i] !== 1'b1) bad++;
      end
      return bad;
   endfunction

   function automatic int lowsAfter(int startIdx);
      int n;
      n = 0;
      for (int i = startIdx; i < txLog.size(); i++) begin
         if (txLog[i] !== 1'b1) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      logic [31:0] v;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h4) begin errors++; $display("FAIL reset_status: got %h want 4", v); end
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'd868) begin errors++; $display("FAIL reset_div: got %0d want 868", v); end
      busWrite(A_RSVD, 4'hF, $urandom);
      busRead(A_RSVD, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want 0", v); end
   endtask

   task automatic test_single_frame();
      logic [31:0] v;
      logic [31:0] firstStatus;
      logic [31:0] busyStatus;
      logic [7:0]  q[$];
      int startIdx;
      int firstIdle;
      busWrite(A_DIV, 4'b0011, 32'd4);
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'd4) begin errors++; $display("FAIL div_write: got %0d want 4", v); end
      busWrite(A_DATA, 4'b0001, 32'h55);
      startIdx = txLog.size();
      firstIdle = -1;
      firstStatus = '0;
      busyStatus = '0;
      for (int k = 1; k <= 200; k++) begin
         busRead(A_STATUS, v);
         if (k == 1) firstStatus = v;
         if (k == 2) busyStatus = v;
         if (k >= 2 && v[0] == 1'b0) begin
            firstIdle = k;
            break;
         end
      end
      checks++;
      if (firstStatus !== 32'h10) begin errors++; $display("FAIL status_queued: got %h want 10", firstStatus); end
      checks++;
      if (busyStatus !== 32'h5) begin errors++; $display("FAIL status_busy: got %h want 5", busyStatus); end
      checks++;
      if (firstIdle !== 42) begin errors++; $display("FAIL busy_clear: got read %0d want 42", firstIdle); end
      repeat (5) @(posedge clk);
      q.push_back(8'h55);
      checks++;
      v = frameMismatches(startIdx, q, 4);
      if (v !== 0) begin errors++; $display("FAIL frame_55: bad samples %0d want 0", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [7:0]  q[$];
      int startIdx;
      q = '{8'hA5, 8'h3C, 8'hFF};
      busWrite(A_DIV, 4'b0011, 32'd2);
      busWrite(A_DATA, 4'b0001, {24'b0, q[0]});
      startIdx = txLog.size();
      busWrite(A_DATA, 4'b0001, {24'b0, q[1]});
      busWrite(A_DATA, 4'b0001, {24'b0, q[2]});
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h21) begin errors++; $display("FAIL b2b_count: got %h want 21", v); end
      repeat (10 * 2 * 3 + 10) @(posedge clk);
      checks++;
      v = frameMismatches(startIdx, q, 2);
      if (v !== 0) begin errors++; $display("FAIL frames_b2b: bad samples %0d want 0", v); end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [7:0]  q[$];
      int startIdx;
      int divV;
      int n;
      for (int it = 0; it < 4; it++) begin
         q.delete();
         divV = $urandom_range(1, 3);
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         busWrite(A_DIV, 4'b0011, 32'(divV));
         startIdx = 0;
         for (int i = 0; i < n; i++) begin
            busWrite(A_DATA, {3'($urandom), 1'b1}, {24'($urandom), q[i]});
            if (i == 0) startIdx = txLog.size();
         end
         repeat (10 * divV * n + 20) @(posedge clk);
         checks++;
         v = frameMismatches(startIdx, q, divV);
         if (v !== 0) begin
            errors++;
            $display("FAIL frames_random%0d: bad samples %0d want 0 (div %0d, %0d bytes)", it, v, divV, n);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      logic [7:0]  sent[$];
      logic [7:0]  expectQ[$];
      int startIdx;
      int held;
      busWrite(A_DIV, 4'b0011, 32'd3);
      startIdx = 0;
      held = 0;
      // Model: the first byte goes straight to the line; the FIFO holds DEPTH more.
      for (int i = 0; i < DEPTH + 2; i++) begin
         sent.push_back(8'($urandom));
         busWrite(A_DATA, 4'b0001, {24'b0, sent[i]});
         if (i == 0) begin
            startIdx = txLog.size();
            expectQ.push_back(sent[i]);
         end else if (held < DEPTH) begin
            held++;
            expectQ.push_back(sent[i]);
         end
      end
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h8B) begin errors++; $display("FAIL ovf_status: got %h want 8b", v); end
      busWrite(A_STATUS, 4'b0001, 32'h0);
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h8B) begin errors++; $display("FAIL ovf_keep: got %h want 8b", v); end
      busWrite(A_STATUS, 4'b0001, 32'h8);
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h83) begin errors++; $display("FAIL ovf_clear: got %h want 83", v); end
      repeat (10 * 3 * (DEPTH + 1) + 20) @(posedge clk);
      checks++;
      v = frameMismatches(startIdx, expectQ, 3);
      if (v !== 0) begin errors++; $display("FAIL frames_ovf: bad samples %0d want 0", v); end
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h4) begin errors++; $display("FAIL ovf_drained: got %h want 4", v); end
   endtask

   task automatic test_div_zero();
      logic [31:0] v;
      logic [7:0]  q[$];
      int startIdx;
      busWrite(A_DIV, 4'b0011, 32'h0);
      busWrite(A_DIV, 4'b0010, 32'h1234_5678);
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'h5600) begin errors++; $display("FAIL div_lane1: got %h want 5600", v); end
      busWrite(A_DIV, 4'b0001, 32'hFFFF_FF34);
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'h5634) begin errors++; $display("FAIL div_lane0: got %h want 5634", v); end
      busWrite(A_DIV, 4'b0011, 32'h0);
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL div_zero_read: got %h want 0", v); end
      busWrite(A_DATA, 4'b1110, 32'hFFFF_FF01);
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h4) begin errors++; $display("FAIL data_lane_ignored: got %h want 4", v); end
      q.push_back(8'h01);
      busWrite(A_DATA, 4'b0001, 32'h01);
      startIdx = txLog.size();
      repeat (20) @(posedge clk);
      checks++;
      v = frameMismatches(startIdx, q, 1);
      if (v !== 0) begin errors++; $display("FAIL frame_div0: bad samples %0d want 0", v); end
      busRead(A_STATUS, v);
      @(negedge clk);
      sel = 1'b0; addr = A_STATUS;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL unselected_read: got %h want 0", rdata); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v;
      int startIdx;
      busWrite(A_DIV, 4'b0011, 32'd4);
      busWrite(A_DATA, 4'b0001, 32'h00);
      busWrite(A_DATA, 4'b0001, 32'h00);
      repeat (14) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b want 0", tx); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", tx); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      busRead(A_STATUS, v);
      checks++;
      if (v !== 32'h4) begin errors++; $display("FAIL post_reset_status: got %h want 4", v); end
      busRead(A_DIV, v);
      checks++;
      if (v !== 32'd868) begin errors++; $display("FAIL post_reset_div: got %0d want 868", v); end
      startIdx = txLog.size();
      repeat (60) @(posedge clk);
      checks++;
      v = lowsAfter(startIdx);
      if (v !== 0) begin errors++; $display("FAIL no_frame_after_reset: low samples %0d want 0", v); end
   endtask

   initial begin
      resetn = 1'b0;
      sel = 1'b0;
      addr = 2'd0;
      wen = 4'b0;
      wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL in_reset: rdata %h tx %b want 0 and 1", rdata, tx);
      end
      @(negedge clk);
      resetn = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_random();
      test_overflow();
      test_div_zero();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
